memory_stage: RTL and testbench
===============================

// Module: memory_stage
// PURPOSE
//  Consumer side of the execute->memory pipeline interface. Takes the EX/MEM register outputs
//  (address, write data, WA3M, PCSrcM/RegWriteM/MemToRegM) plus MemWriteM.
//  Runs the load/store handshake to the data memory (variable wait states; camera frame buffer
//  shares the bus) and stalls the pipe until the access completes.
//  Contains the MEM/WB pipeline register feeding writeback, and returns ALUOutM for forwarding.
// PARAMETERS
//  TIMEOUT_CYCLES  255           max WAIT cycles before abort; must be >=1
//  ERR_DATA        32'hDEADBEEF  read data returned on aborted load
// PORTS
//  Clk          in   1   single clock, rising edge
//  Rst_n        in   1   asynchronous, active-low reset
//  AToMemM      in   32  ALU result / memory address from EX/MEM
//  WDToMemM     in   32  store data from EX/MEM
//  WA3M         in   4   destination register
//  PCSrcM       in   1   writes PC (already cond-gated)
//  RegWriteM    in   1   register write (already cond-gated)
//  MemToRegM    in   1   instruction is a load
//  MemWriteM    in   1   instruction is a store (cond-gated)
//  mem_req      out  1   request to data memory, registered
//  mem_we       out  1   1=write, registered
//  mem_addr     out  32  registered address
//  mem_wdata    out  32  registered write data
//  mem_rdata    in   32  read data, valid while mem_ack=1
//  mem_ack      in   1   single-cycle completion
//  StallM       out  1   to hazard unit: hold IF..EX/MEM registers
//  ALUOutM      out  32  = AToMemM, combinational forwarding path (ADataMem)
//  ReadDataW    out  32  MEM/WB: load data
//  ALUOutW      out  32  MEM/WB: ALU result
//  WA3W         out  4   MEM/WB: destination register
//  PCSrcW, RegWriteW, MemToRegW  out 1 each  MEM/WB control
//  MemFault     out  1   sticky: some access timed out
// BEHAVIOUR
//  - Reset (Rst_n=0, async): state IDLE, timeout counter 0. All registered outputs 0:
//    mem_*, MEM/WB fields, MemFault. Reset mid-access drops mem_req at once; access abandoned.
//  - AccessM = MemToRegM | MemWriteM. If both are set, it is a store.
//  - FSM IDLE:
//    - AccessM=1: latch AToMemM/WDToMemM/MemWriteM into mem_addr/mem_wdata/mem_we.
//      Set mem_req=1; go to WAIT with cnt=0.
//    - mem_ack while IDLE is ignored.
//  - FSM WAIT:
//    - mem_req, mem_addr, mem_wdata and mem_we are held stable.
//    - mem_ack=1: done. Clear mem_req on the next edge; go to IDLE.
//    - Else if cnt==TIMEOUT_CYCLES-1: abort. Treat as done with rdata=ERR_DATA, set MemFault,
//      clear mem_req, go to IDLE.
//    - Else cnt++.
//  - Done = (WAIT & (mem_ack | timeout)). StallM = AccessM & ~Done (combinational).
//    Non-access instructions never stall.
//  - Latency: a memory access occupies >=2 cycles (issue + >=1 WAIT). Best case ack on the
//    first WAIT cycle -> StallM high exactly 1 cycle.
//  - Back-to-back accesses: the next instruction arrives on the Done edge. It sees IDLE and
//    issues, so mem_req is 0 for exactly one cycle between requests.
//  - MEM/WB register, every edge:
//    - StallM=1: insert bubble. RegWriteW=PCSrcW=MemToRegW=0; data fields keep prior values.
//    - Else: capture ALUOutW<=AToMemM, WA3W, PCSrcW, RegWriteW, MemToRegW.
//      ReadDataW <= mem_rdata (or ERR_DATA on abort) for loads, else 32'h0.
//  - The held EX/MEM instruction commits to WB exactly once.
//  - MemFault clears only on reset.
// STRUCTURE
//  - Shared package arm_pkg: mem_state_t enum {MS_IDLE, MS_WAIT}; ERR_DATA default constant.
//  - Sub-module pipe_mem_wb: MEM/WB register with bubble input, async active-low reset.
//  - The FSM and timeout counter ($clog2(TIMEOUT_CYCLES) bits) stay in memory_stage.
// TESTING
//  - ALU op (RegWriteM=1, AToMemM=0x10, WA3M=3), no access -> StallM=0, mem_req never 1;
//    next edge ALUOutW=0x10, WA3W=3, RegWriteW=1.
//  - Load A=0x100, ack 3 cycles after req, rdata=0x12345678 -> StallM high 3 cycles;
//    exactly one WB commit: ReadDataW=0x12345678, MemToRegW=1; bubbles (RegWriteW=0) before it.
//  - Store A=0x200, WD=0xCAFEF00D, ack on first WAIT cycle -> mem_we=1, addr/wdata stable
//    while req; StallM 1 cycle; ReadDataW=0.
//  - Two loads back-to-back, immediate ack -> mem_req pattern 1,0,1; both commit in order.
//  - TIMEOUT_CYCLES=4, load, no ack -> abort after 4 WAIT cycles; ReadDataW=0xDEADBEEF;
//    MemFault=1 until reset.
//  - Rst_n low during WAIT -> mem_req=0 immediately; after release IDLE, all outputs 0,
//    no WB commit.

Source files
------------

// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared types and constants for the memory pipeline stage
package arm_pkg;

  typedef enum logic {
    MS_IDLE = 1'b0,
    MS_WAIT = 1'b1
  } mem_state_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/pipe_mem_wb.sv
// rtl/pipe_mem_wb.sv - MEM/WB pipeline register with bubble insertion
module pipe_mem_wb (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bubble,
  input  logic [31:0] alu_out_m,
  input  logic [31:0] read_data_m,
  input  logic [3:0]  wa3_m,
  input  logic        pcsrc_m,
  input  logic        reg_write_m,
  input  logic        mem_to_reg_m,
  output logic [31:0] alu_out_w,
  output logic [31:0] read_data_w,
  output logic [3:0]  wa3_w,
  output logic        pcsrc_w,
  output logic        reg_write_w,
  output logic        mem_to_reg_w
);

  // A bubble only kills the control bits; data fields keep their last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out_w    <= 32'h0;
      read_data_w  <= 32'h0;
      wa3_w        <= 4'h0;
      pcsrc_w      <= 1'b0;
      reg_write_w  <= 1'b0;
      mem_to_reg_w <= 1'b0;
    end else if (bubble) begin
      pcsrc_w      <= 1'b0;
      reg_write_w  <= 1'b0;
      mem_to_reg_w <= 1'b0;
    end else begin
      alu_out_w    <= alu_out_m;
      read_data_w  <= read_data_m;
      wa3_w        <= wa3_m;
      pcsrc_w      <= pcsrc_m;
      reg_write_w  <= reg_write_m;
      mem_to_reg_w <= mem_to_reg_m;
    end
  end

endmodule

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - memory pipeline stage: data-memory handshake, stall, timeout, MEM/WB
module memory_stage
  import arm_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [31:0] AToMemM,
  input  logic [31:0] WDToMemM,
  input  logic [3:0]  WA3M,
  input  logic        PCSrcM,
  input  logic        RegWriteM,
  input  logic        MemToRegM,
  input  logic        MemWriteM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        StallM,
  output logic [31:0] ALUOutM,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUOutW,
  output logic [3:0]  WA3W,
  output logic        PCSrcW,
  output logic        RegWriteW,
  output logic        MemToRegW,
  output logic        MemFault
);

  localparam int             CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             req_next, we_next, fault_next;
  logic [31:0]      addr_next, wdata_next;

  logic        access, is_load, in_wait, timeout, done;
  logic [31:0] load_data;

  // A store wins when both load and store flags are set.
  assign access    = MemToRegM | MemWriteM;
  assign is_load   = MemToRegM & ~MemWriteM;
  assign in_wait   = (state == MS_WAIT);
  assign timeout   = in_wait & ~mem_ack & (cnt == CNT_LAST);
  assign done      = in_wait & (mem_ack | timeout);
  assign StallM    = access & ~done;
  assign ALUOutM   = AToMemM;
  assign load_data = is_load ? (timeout ? ERR_DATA : mem_rdata) : 32'h0;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= MS_IDLE;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      MemFault  <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      mem_req   <= req_next;
      mem_we    <= we_next;
      mem_addr  <= addr_next;
      mem_wdata <= wdata_next;
      MemFault  <= fault_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    req_next   = mem_req;
    we_next    = mem_we;
    addr_next  = mem_addr;
    wdata_next = mem_wdata;
    fault_next = MemFault;
    case (state)
      MS_IDLE: begin
        if (access) begin
          state_next = MS_WAIT;
          cnt_next   = '0;
          req_next   = 1'b1;
          we_next    = MemWriteM;
          addr_next  = AToMemM;
          wdata_next = WDToMemM;
        end
      end
      MS_WAIT: begin
        if (done) begin
          state_next = MS_IDLE;
          req_next   = 1'b0;
          if (timeout) fault_next = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: state_next = MS_IDLE;
    endcase
  end

  pipe_mem_wb u_mem_wb (
    .clk          (Clk),
    .rst_n        (Rst_n),
    .bubble       (StallM),
    .alu_out_m    (AToMemM),
    .read_data_m  (load_data),
    .wa3_m        (WA3M),
    .pcsrc_m      (PCSrcM),
    .reg_write_m  (RegWriteM),
    .mem_to_reg_m (is_load),
    .alu_out_w    (ALUOutW),
    .read_data_w  (ReadDataW),
    .wa3_w        (WA3W),
    .pcsrc_w      (PCSrcW),
    .reg_write_w  (RegWriteW),
    .mem_to_reg_w (MemToRegW)
  );

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - self-checking bench for memory_stage with a cycle-timeline model
module tb_memory_stage;

  localparam int T    = 4;
  localparam int NI   = 7;
  localparam int NCYC = 20;

  typedef struct {
    logic [31:0] a, wd, rdata;
    logic [3:0]  wa3;
    logic        pcsrc, regw, mtr, mw;
    int          lat;
  } instr_t;

  typedef struct {
    logic [31:0] alu, rd;
    logic [3:0]  wa3;
    logic        pcsrc, regw, mtr;
  } wb_t;

  logic        Clk = 1'b0, Rst_n;
  logic [31:0] AToMemM, WDToMemM, mem_rdata;
  logic [3:0]  WA3M;
  logic        PCSrcM, RegWriteM, MemToRegM, MemWriteM, mem_ack;
  logic        mem_req, mem_we, StallM, PCSrcW, RegWriteW, MemToRegW, MemFault;
  logic [31:0] mem_addr, mem_wdata, ALUOutM, ReadDataW, ALUOutW;
  logic [3:0]  WA3W;

  memory_stage #(.TIMEOUT_CYCLES(T)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .AToMemM(AToMemM), .WDToMemM(WDToMemM), .WA3M(WA3M),
    .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemToRegM(MemToRegM), .MemWriteM(MemWriteM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .StallM(StallM), .ALUOutM(ALUOutM),
    .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .WA3W(WA3W), .PCSrcW(PCSrcW),
    .RegWriteW(RegWriteW), .MemToRegW(MemToRegW), .MemFault(MemFault)
  );

  always #5 Clk = ~Clk;

  int checks = 0, errors = 0;
  bit chk_en = 1'b0;
  int tc = 0;
  int stall_i1 = 0;

  instr_t prog[NI];
  instr_t nop;
  logic   e_stall[NCYC], e_req[NCYC], e_we[NCYC], e_fault[NCYC];
  logic [31:0] e_addr[NCYC], e_wdata[NCYC], e_am[NCYC];
  wb_t    e_wb[NCYC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic instr_t mk(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wa3,
                                input logic pc, input logic rw, input logic mtr, input logic mw,
                                input int lat, input logic [31:0] rd);
    instr_t x;
    x.a = a; x.wd = wd; x.wa3 = wa3; x.pcsrc = pc; x.regw = rw;
    x.mtr = mtr; x.mw = mw; x.lat = lat; x.rdata = rd;
    return x;
  endfunction

  task automatic drive(input instr_t x);
    AToMemM = x.a; WDToMemM = x.wd; WA3M = x.wa3; PCSrcM = x.pcsrc;
    RegWriteM = x.regw; MemToRegM = x.mtr; MemWriteM = x.mw;
  endtask

  // Each instruction sits in MEM for (stall cycles + 1); the commit appears one cycle after its last.
  task automatic build_model;
    wb_t    wb;
    logic   fault;
    int     t, n;
    logic   acc, ld;
    instr_t x;
    wb = '{alu: 32'h0, rd: 32'h0, wa3: 4'h0, pcsrc: 1'b0, regw: 1'b0, mtr: 1'b0};
    fault = 1'b0;
    t = 0;
    for (int i = 0; t < NCYC; i++) begin
      x   = (i < NI) ? prog[i] : nop;
      acc = x.mtr | x.mw;
      ld  = x.mtr & ~x.mw;
      n   = acc ? ((x.lat == 0) ? T : x.lat) : 0;
      for (int k = 0; k <= n && t < NCYC; k++) begin
        e_stall[t] = (k < n);
        e_req[t]   = acc && (k >= 1);
        e_addr[t]  = x.a;
        e_wdata[t] = x.wd;
        e_we[t]    = x.mw;
        e_am[t]    = x.a;
        e_wb[t]    = wb;
        e_fault[t] = fault;
        t++;
        if (k < n) begin
          wb.pcsrc = 1'b0; wb.regw = 1'b0; wb.mtr = 1'b0;
        end else begin
          wb.alu = x.a; wb.wa3 = x.wa3; wb.pcsrc = x.pcsrc; wb.regw = x.regw; wb.mtr = ld;
          wb.rd  = ld ? ((x.lat == 0) ? 32'hDEADBEEF : x.rdata) : 32'h0;
          if (acc && x.lat == 0) fault = 1'b1;
        end
      end
    end
  endtask

  always @(negedge Clk) begin
    if (chk_en && tc < NCYC) begin
      check($sformatf("stall[%0d]", tc), {31'h0, StallM}, {31'h0, e_stall[tc]});
      check($sformatf("req[%0d]", tc), {31'h0, mem_req}, {31'h0, e_req[tc]});
      if (e_req[tc]) begin
        check($sformatf("addr[%0d]", tc), mem_addr, e_addr[tc]);
        check($sformatf("wdata[%0d]", tc), mem_wdata, e_wdata[tc]);
        check($sformatf("we[%0d]", tc), {31'h0, mem_we}, {31'h0, e_we[tc]});
      end
      check($sformatf("aluoutm[%0d]", tc), ALUOutM, e_am[tc]);
      check($sformatf("aluoutw[%0d]", tc), ALUOutW, e_wb[tc].alu);
      check($sformatf("readdataw[%0d]", tc), ReadDataW, e_wb[tc].rd);
      check($sformatf("wa3w[%0d]", tc), {28'h0, WA3W}, {28'h0, e_wb[tc].wa3});
      check($sformatf("ctrlw[%0d]", tc), {29'h0, PCSrcW, RegWriteW, MemToRegW},
            {29'h0, e_wb[tc].pcsrc, e_wb[tc].regw, e_wb[tc].mtr});
      check($sformatf("fault[%0d]", tc), {31'h0, MemFault}, {31'h0, e_fault[tc]});
      if (tc >= 1 && tc <= 4 && StallM) stall_i1++;
      case (tc)
        1: begin
          check("lit alu_op aluoutw", ALUOutW, 32'h10);
          check("lit alu_op wa3w", {28'h0, WA3W}, 32'd3);
          check("lit alu_op regwritew", {31'h0, RegWriteW}, 32'd1);
        end
        5: begin
          check("lit load stall cycles", stall_i1, 32'd3);
          check("lit load readdataw", ReadDataW, 32'h12345678);
          check("lit load memtoregw", {31'h0, MemToRegW}, 32'd1);
        end
        6: begin
          check("lit store we", {31'h0, mem_we}, 32'd1);
          check("lit store wdata", mem_wdata, 32'hCAFEF00D);
        end
        7: check("lit store readdataw", ReadDataW, 32'h0);
        8: check("lit b2b req1", {31'h0, mem_req}, 32'd1);
        9: check("lit b2b gap", {31'h0, mem_req}, 32'd0);
        10: check("lit b2b req2", {31'h0, mem_req}, 32'd1);
        16: begin
          check("lit abort readdataw", ReadDataW, 32'hDEADBEEF);
          check("lit abort fault", {31'h0, MemFault}, 32'd1);
        end
        17: begin
          check("lit last aluoutw", ALUOutW, 32'h55);
          check("lit last pcsrcw", {31'h0, PCSrcW}, 32'd1);
        end
        default: ;
      endcase
      tc++;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, " mem_req"}, {31'h0, mem_req}, 32'h0);
    check({tag, " mem_we"}, {31'h0, mem_we}, 32'h0);
    check({tag, " mem_addr"}, mem_addr, 32'h0);
    check({tag, " mem_wdata"}, mem_wdata, 32'h0);
    check({tag, " aluoutw"}, ALUOutW, 32'h0);
    check({tag, " readdataw"}, ReadDataW, 32'h0);
    check({tag, " wa3w"}, {28'h0, WA3W}, 32'h0);
    check({tag, " ctrlw"}, {29'h0, PCSrcW, RegWriteW, MemToRegW}, 32'h0);
    check({tag, " fault"}, {31'h0, MemFault}, 32'h0);
  endtask

  initial begin
    instr_t cur;
    int     idx, wcnt;
    bit     adv;
    nop     = mk(32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 32'h0);
    prog[0] = mk(32'h10,  32'h0,        4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 0, 32'h0);
    prog[1] = mk(32'h100, 32'h0,        4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 3, 32'h12345678);
    prog[2] = mk(32'h200, 32'hCAFEF00D, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 32'h0);
    prog[3] = mk(32'h300, 32'h0,        4'd6, 1'b0, 1'b1, 1'b1, 1'b0, 1, 32'h11111111);
    prog[4] = mk(32'h304, 32'h0,        4'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1, 32'h22222222);
    prog[5] = mk(32'h400, 32'h0,        4'd8, 1'b0, 1'b1, 1'b1, 1'b0, 0, 32'h0);
    prog[6] = mk(32'h55,  32'h0,        4'd9, 1'b1, 1'b1, 1'b0, 1'b0, 0, 32'h0);
    build_model();

    Rst_n = 1'b0;
    drive(nop);
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    repeat (2) @(negedge Clk);
    check_all_zero("reset");
    check("reset stall", {31'h0, StallM}, 32'h0);
    Rst_n = 1'b1;

    @(posedge Clk); #1;
    idx = 0; wcnt = 0;
    drive(prog[0]);
    chk_en = 1'b1;
    for (int t = 0; t < NCYC; t++) begin
      @(negedge Clk);
      adv = !StallM;
      @(posedge Clk); #1;
      if (adv) idx++;
      cur = (idx < NI) ? prog[idx] : nop;
      drive(cur);
      if (mem_req) wcnt++; else wcnt = 0;
      if (mem_req && cur.lat != 0 && wcnt == cur.lat) begin
        mem_ack = 1'b1; mem_rdata = cur.rdata;
      end else begin
        mem_ack = 1'b0; mem_rdata = 32'hA5A5A5A5;
      end
    end
    chk_en = 1'b0;

    drive(mk(32'h500, 32'h0, 4'd2, 1'b0, 1'b1, 1'b1, 1'b0, 0, 32'h0));
    mem_ack = 1'b0;
    @(posedge Clk); #1;
    @(posedge Clk);
    @(negedge Clk);
    check("midreset req before", {31'h0, mem_req}, 32'd1);
    Rst_n = 1'b0;
    #1;
    check("midreset req drop", {31'h0, mem_req}, 32'h0);
    check_all_zero("midreset");
    drive(nop);
    @(negedge Clk);
    Rst_n = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check_all_zero("postreset");
    check("postreset stall", {31'h0, StallM}, 32'h0);
    @(posedge Clk); #1;
    drive(mk(32'h600, 32'h0, 4'd4, 1'b0, 1'b1, 1'b1, 1'b0, 0, 32'h0));
    @(negedge Clk);
    check("postreset idle issue stall", {31'h0, StallM}, 32'd1);
    check("postreset idle issue req", {31'h0, mem_req}, 32'h0);
    @(negedge Clk);
    check("postreset req", {31'h0, mem_req}, 32'd1);
    check("postreset addr", mem_addr, 32'h600);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
